johnson_seq_monitor: RTL and testbench
======================================

Name: johnson_seq_monitor

Overview:
Downstream consumer of the 4-bit Johnson counter output. It decodes the Johnson code to a 3-bit phase and checks that each new code is the legal successor of the previous one. It tracks lock, raises sticky faults and counts full revolutions. It sits between the Johnson counter and any logic that needs a trusted phase index or revolution tick.

Parameters:
LOCK_CNT, 2, consecutive good successor steps required to enter LOCKED (1..7)
ALLOW_HOLD, 1, 1 = a repeated code is legal (no error); 0 = a repeat is a sequence error
REV_W, 8, width of the revolution counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  sample enable; jc_in is evaluated only when en=1
clr  input  1  synchronous clear of fault, rev_count and tracking state
jc_in  input  4  Johnson code from the upstream counter
phase  output  3  decoded phase of the last sample
phase_valid  output  1  last sample was a legal code
illegal  output  1  one-cycle pulse: last sample was not one of the 8 legal codes
seq_err  output  1  one-cycle pulse: legal code that is not a permitted successor of the previous one
locked  output  1  FSM is in LOCKED
fault  output  1  sticky; FSM is in FAULT
wrap  output  1  one-cycle pulse on a 7->0 step while LOCKED
rev_count  output  REV_W  number of wraps while LOCKED, modulo 2^REV_W

Behaviour:
- Decode map: 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, 0111->5, 0011->6, 0001->7. Any other code is illegal.
- Latency: all outputs are registered and reflect the jc_in sampled on the previous rising edge with en=1.
- Reset: all outputs are 0, the FSM is IDLE, prev_valid=0, and good_cnt=0.
- en=0: no evaluation. State, prev_phase, phase, phase_valid, locked, fault and rev_count hold. The illegal, seq_err and wrap pulses drop to 0.
- clr=1 has priority over en: FSM goes to IDLE, fault=0, rev_count=0, prev_valid=0, and all pulses are 0. The sample in that cycle is ignored.
- Step classification (en=1, legal code, prev_valid=1):
  - GOOD: new phase = prev_phase+1 mod 8.
  - HOLD: new phase = prev_phase. This is GOOD if ALLOW_HOLD=1 and does not advance good_cnt; otherwise it is BAD.
  - BAD: any other phase.
- prev_phase and prev_valid are updated on every legal sample, including BAD ones. An illegal sample sets prev_valid=0.
- FSM states: IDLE, TRACK, LOCKED, FAULT.
  - IDLE: on a legal sample go to TRACK with good_cnt=0. An illegal sample pulses illegal and stays in IDLE.
  - TRACK: a GOOD advancing step increments good_cnt; on reaching LOCK_CNT go to LOCKED. A BAD step pulses seq_err, stays in TRACK and sets good_cnt=0. An illegal sample pulses illegal and goes to IDLE.
  - LOCKED: GOOD and HOLD steps stay in LOCKED. A GOOD step from 7 to 0 pulses wrap and increments rev_count, wrapping at 2^REV_W without saturation. A BAD step (seq_err) or an illegal sample (illegal) goes to FAULT.
  - FAULT: samples are still decoded and error pulses still fire. locked=0 and fault=1 until clr or reset.
- seq_err and illegal are never asserted together. wrap is never asserted outside LOCKED.
- Asynchronous reset mid-operation clears everything immediately. There are no partial updates.

Decomposition:
- Shared package johnson_pkg holds:
  - the 8 legal code constants and the state enum {IDLE, TRACK, LOCKED, FAULT};
  - a decode function returning {legal, phase[2:0]}.
- Natural sub-module: johnson_decode, purely combinational, jc_in -> legal, phase. The upstream testbench reuses it.
- The FSM, counters and registers stay in johnson_seq_monitor.

Test Plan:
- Lock-in (LOCK_CNT=2): after reset, feed 0000, 1000, 1100, 1110 with en=1. Required: phase 0,1,2,3 one cycle later; locked=1 after the 1100 sample; illegal=0 and seq_err=0 throughout.
- Revolutions: once locked at phase 3, run 16 more legal steps. Required: wrap pulses exactly twice, each on the 0001->0000 step, and rev_count=2.
- Illegal code while locked: feed 1010. Required: illegal=1 for one cycle, phase_valid=0, locked=0, fault=1; fault stays 1 for 5 further legal steps.
- Skip while locked: 1000 followed by 1110. Required: seq_err=1 for one cycle and fault=1. Then assert clr together with a legal sample. Required: fault=0, rev_count=0, FSM in IDLE, and that sample ignored.
- Hold handling: while locked, feed 1100, 1100, 1110 with ALLOW_HOLD=1. Required: no seq_err and locked stays 1. Repeat with ALLOW_HOLD=0. Required: seq_err on the second 1100 and fault=1.
- Async reset mid-lock: assert reset between clock edges with rev_count=3. Required: all outputs 0 before the next edge; after release, 0000 then 1000 does not lock with LOCK_CNT=2.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson-code monitor: legal code table, FSM states
// and the code-to-phase decode used by both the monitor and upstream benches.
package johnson_pkg;

   localparam int unsigned CODE_W  = 4;
   localparam int unsigned PHASE_W = 3;

   localparam logic [CODE_W-1:0] JC_0 = 4'b0000;
   localparam logic [CODE_W-1:0] JC_1 = 4'b1000;
   localparam logic [CODE_W-1:0] JC_2 = 4'b1100;
   localparam logic [CODE_W-1:0] JC_3 = 4'b1110;
   localparam logic [CODE_W-1:0] JC_4 = 4'b1111;
   localparam logic [CODE_W-1:0] JC_5 = 4'b0111;
   localparam logic [CODE_W-1:0] JC_6 = 4'b0011;
   localparam logic [CODE_W-1:0] JC_7 = 4'b0001;

   typedef enum logic [1:0] {IDLE, TRACK, LOCKED, FAULT} state_t;

   typedef struct packed {
      logic               legal;
      logic [PHASE_W-1:0] phase;
   } dec_t;

   // Illegal codes decode to {legal=0, phase=0}.
   function automatic dec_t jc_decode(input logic [CODE_W-1:0] jc);
      dec_t d;
      d.legal = 1'b1;
      d.phase = '0;
      case (jc)
         JC_0:    d.phase = 3'd0;
         JC_1:    d.phase = 3'd1;
         JC_2:    d.phase = 3'd2;
         JC_3:    d.phase = 3'd3;
         JC_4:    d.phase = 3'd4;
         JC_5:    d.phase = 3'd5;
         JC_6:    d.phase = 3'd6;
         JC_7:    d.phase = 3'd7;
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/johnson_seq_monitor_decode.sv
// Purely combinational Johnson code decoder: jc_in -> legal, phase.
module johnson_decode
   import johnson_pkg::*;
(
   input  logic [CODE_W-1:0]  jc_in,
   output logic               legal,
   output logic [PHASE_W-1:0] phase
);

   dec_t dec;

   always_comb begin
      dec   = jc_decode(jc_in);
      legal = dec.legal;
      phase = dec.phase;
   end

endmodule

// File: rtl/johnson_seq_monitor.sv
// Johnson sequence monitor: decodes phase, checks successor legality, tracks lock,
// latches faults and counts full revolutions while locked.
module johnson_seq_monitor
   import johnson_pkg::*;
#(
   parameter int unsigned LOCK_CNT   = 2,
   parameter bit          ALLOW_HOLD = 1'b1,
   parameter int unsigned REV_W      = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               clr,
   input  logic [CODE_W-1:0]  jc_in,
   output logic [PHASE_W-1:0] phase,
   output logic               phase_valid,
   output logic               illegal,
   output logic               seq_err,
   output logic               locked,
   output logic               fault,
   output logic               wrap,
   output logic [REV_W-1:0]   rev_count
);

   localparam int unsigned CNT_W = 3;

   state_t             state;
   logic [PHASE_W-1:0] prev_phase;
   logic               prev_valid;
   logic [CNT_W-1:0]   good_cnt;

   logic               dec_legal;
   logic [PHASE_W-1:0] dec_phase;
   logic [PHASE_W-1:0] succ_phase;
   logic               step_adv;
   logic               step_hold;
   logic               step_bad;

   johnson_decode u_decode (
      .jc_in (jc_in),
      .legal (dec_legal),
      .phase (dec_phase)
   );

   // Step classification against the previous legal sample.
   always_comb begin
      succ_phase = prev_phase + 3'd1;
      step_adv   = prev_valid && (dec_phase == succ_phase);
      step_hold  = prev_valid && (dec_phase == prev_phase);
      step_bad   = prev_valid && !step_adv && !(step_hold && ALLOW_HOLD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         prev_phase  <= '0;
         prev_valid  <= 1'b0;
         good_cnt    <= '0;
         phase       <= '0;
         phase_valid <= 1'b0;
         illegal     <= 1'b0;
         seq_err     <= 1'b0;
         locked      <= 1'b0;
         fault       <= 1'b0;
         wrap        <= 1'b0;
         rev_count   <= '0;
      end else begin
         illegal <= 1'b0;
         seq_err <= 1'b0;
         wrap    <= 1'b0;
         if (clr) begin
            state      <= IDLE;
            prev_valid <= 1'b0;
            good_cnt   <= '0;
            locked     <= 1'b0;
            fault      <= 1'b0;
            rev_count  <= '0;
         end else if (en) begin
            phase       <= dec_phase;
            phase_valid <= dec_legal;
            prev_valid  <= dec_legal;
            if (!dec_legal) begin
               illegal <= 1'b1;
               case (state)
                  TRACK:   state <= IDLE;
                  LOCKED: begin
                     state  <= FAULT;
                     locked <= 1'b0;
                     fault  <= 1'b1;
                  end
                  default: ;
               endcase
            end else begin
               prev_phase <= dec_phase;
               case (state)
                  IDLE: begin
                     state    <= TRACK;
                     good_cnt <= '0;
                  end
                  TRACK: begin
                     if (step_bad) begin
                        seq_err  <= 1'b1;
                        good_cnt <= '0;
                     end else if (step_adv) begin
                        if (good_cnt == CNT_W'(LOCK_CNT - 1)) begin
                           state  <= LOCKED;
                           locked <= 1'b1;
                        end
                        good_cnt <= good_cnt + 3'd1;
                     end
                  end
                  LOCKED: begin
                     if (step_bad) begin
                        seq_err <= 1'b1;
                        state   <= FAULT;
                        locked  <= 1'b0;
                        fault   <= 1'b1;
                     end else if (step_adv && prev_phase == 3'd7) begin
                        wrap      <= 1'b1;
                        rev_count <= rev_count + REV_W'(1);
                     end
                  end
                  FAULT: begin
                     if (step_bad) seq_err <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Scoreboard bench for johnson_seq_monitor: two instances (hold legal / hold illegal)
// share one stimulus stream and are checked against an abstract sequence model.
module tb_johnson_seq_monitor;

   localparam int LOCK = 2;
   localparam int M_IDLE = 0, M_TRACK = 1, M_LOCKED = 2, M_FAULT = 3;

   typedef struct {
      int mode;
      int good;
      bit pvp;
      int prevp;
      int rev;
      int phase;
      bit pvalid;
      bit ill;
      bit serr;
      bit wrap;
   } mdl_t;

   typedef struct packed {
      logic [2:0] phase;
      logic       pvalid;
      logic       ill;
      logic       serr;
      logic       locked;
      logic       fault;
      logic       wrap;
      logic [7:0] rev;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset, en, clr;
   logic [3:0] jc;

   logic [2:0] ph_h, ph_s;
   logic       pv_h, pv_s, il_h, il_s, se_h, se_s, lk_h, lk_s, ft_h, ft_s, wr_h, wr_s;
   logic [7:0] rc_h, rc_s;
   obs_t       act_h, act_s;

   int   n_tests = 0;
   int   n_fail  = 0;
   obs_t q_h[$];
   obs_t q_s[$];
   mdl_t m_h, m_s;
   logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                             4'b1111, 4'b0111, 4'b0011, 4'b0001};

   always #5 clk = ~clk;

   johnson_seq_monitor #(.LOCK_CNT(LOCK), .ALLOW_HOLD(1'b1), .REV_W(8)) dut_hold (
      .clk(clk), .reset(reset), .en(en), .clr(clr), .jc_in(jc),
      .phase(ph_h), .phase_valid(pv_h), .illegal(il_h), .seq_err(se_h),
      .locked(lk_h), .fault(ft_h), .wrap(wr_h), .rev_count(rc_h));

   johnson_seq_monitor #(.LOCK_CNT(LOCK), .ALLOW_HOLD(1'b0), .REV_W(8)) dut_strict (
      .clk(clk), .reset(reset), .en(en), .clr(clr), .jc_in(jc),
      .phase(ph_s), .phase_valid(pv_s), .illegal(il_s), .seq_err(se_s),
      .locked(lk_s), .fault(ft_s), .wrap(wr_s), .rev_count(rc_s));

   assign act_h = {ph_h, pv_h, il_h, se_h, lk_h, ft_h, wr_h, rc_h};
   assign act_s = {ph_s, pv_s, il_s, se_s, lk_s, ft_s, wr_s, rc_s};

   function automatic int lookup(input logic [3:0] c);
      for (int i = 0; i < 8; i++) if (codes[i] == c) return i;
      return -1;
   endfunction

   function automatic mdl_t mreset();
      mdl_t m;
      m.mode = M_IDLE; m.good = 0; m.pvp = 0; m.prevp = 0; m.rev = 0;
      m.phase = 0; m.pvalid = 0; m.ill = 0; m.serr = 0; m.wrap = 0;
      return m;
   endfunction

   // Abstract sequence rules: successor = previous phase + 1 mod 8.
   function automatic mdl_t step(input mdl_t mi, input bit hold_ok, input bit e,
                                 input bit c, input logic [3:0] code);
      mdl_t m = mi;
      int   idx;
      bit   adv, same, bad;
      m.ill = 0; m.serr = 0; m.wrap = 0;
      if (c) begin
         m.mode = M_IDLE; m.pvp = 0; m.good = 0; m.rev = 0;
      end else if (e) begin
         idx = lookup(code);
         if (idx < 0) begin
            m.ill = 1; m.pvalid = 0; m.phase = 0; m.pvp = 0;
            if (m.mode == M_TRACK) m.mode = M_IDLE;
            else if (m.mode == M_LOCKED) m.mode = M_FAULT;
         end else begin
            adv  = m.pvp && idx == (m.prevp + 1) % 8;
            same = m.pvp && idx == m.prevp;
            bad  = m.pvp && !adv && !(same && hold_ok);
            m.pvalid = 1; m.phase = idx;
            if (m.mode == M_IDLE) begin
               m.mode = M_TRACK; m.good = 0;
            end else if (m.mode == M_TRACK) begin
               if (bad) begin m.serr = 1; m.good = 0; end
               else if (adv) begin
                  m.good++;
                  if (m.good >= LOCK) m.mode = M_LOCKED;
               end
            end else if (m.mode == M_LOCKED) begin
               if (bad) begin m.serr = 1; m.mode = M_FAULT; end
               else if (adv && m.prevp == 7) begin m.wrap = 1; m.rev = (m.rev + 1) % 256; end
            end else if (bad) begin
               m.serr = 1;
            end
            m.prevp = idx; m.pvp = 1;
         end
      end
      return m;
   endfunction

   function automatic obs_t to_obs(input mdl_t m);
      obs_t o;
      o.phase = 3'(m.phase); o.pvalid = m.pvalid; o.ill = m.ill; o.serr = m.serr;
      o.locked = (m.mode == M_LOCKED); o.fault = (m.mode == M_FAULT);
      o.wrap = m.wrap; o.rev = 8'(m.rev);
      return o;
   endfunction

   task automatic compare(input string nm, input obs_t e, input obs_t a, input bit mask_ph);
      obs_t em = e;
      obs_t am = a;
      n_tests++;
      if (mask_ph && !e.pvalid) begin em.phase = '0; am.phase = '0; end
      if (em !== am) begin
         n_fail++;
         $display("FAIL %s t=%0t: got ph=%0d pv=%0b ill=%0b serr=%0b lk=%0b flt=%0b wrap=%0b rev=%0d ; expected ph=%0d pv=%0b ill=%0b serr=%0b lk=%0b flt=%0b wrap=%0b rev=%0d",
                  nm, $time, a.phase, a.pvalid, a.ill, a.serr, a.locked, a.fault, a.wrap, a.rev,
                  e.phase, e.pvalid, e.ill, e.serr, e.locked, e.fault, e.wrap, e.rev);
      end
   endtask

   // Monitor: every driven sample produces one registered response after the next edge.
   always @(posedge clk) begin
      #1;
      if (q_h.size() > 0) compare("hold_dut", q_h.pop_front(), act_h, 1'b1);
      if (q_s.size() > 0) compare("strict_dut", q_s.pop_front(), act_s, 1'b1);
   end

   task automatic drive(input bit e, input bit c, input logic [3:0] code);
      @(negedge clk);
      en = e; clr = c; jc = code;
      m_h = step(m_h, 1'b1, e, c, code);
      m_s = step(m_s, 1'b0, e, c, code);
      q_h.push_back(to_obs(m_h));
      q_s.push_back(to_obs(m_s));
   endtask

   task automatic feed(input int ph);
      drive(1'b1, 1'b0, codes[ph % 8]);
   endtask

   // Reset asserted between edges must clear every output before the next edge.
   task automatic async_reset();
      @(posedge clk);
      #3;
      reset = 1'b1; en = 1'b0; clr = 1'b0;
      #1;
      compare("async_reset_hold", '0, act_h, 1'b0);
      compare("async_reset_strict", '0, act_s, 1'b0);
      m_h = mreset(); m_s = mreset();
      q_h.delete(); q_s.delete();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int cur;
      int r, k;
      bit e, c;
      logic [3:0] code;

      reset = 1'b1; en = 1'b0; clr = 1'b0; jc = 4'b0000;
      m_h = mreset(); m_s = mreset();
      repeat (2) @(posedge clk);
      #1;
      compare("reset_hold", '0, act_h, 1'b0);
      compare("reset_strict", '0, act_s, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // Lock-in, then 16 steps for two revolutions.
      for (int p = 0; p < 4; p++) feed(p);
      for (int p = 4; p < 20; p++) feed(p);
      // Illegal code while locked, then five legal steps in FAULT.
      drive(1'b1, 1'b0, 4'b1010);
      for (int p = 4; p < 9; p++) feed(p);
      // Relock at phase 0, skip 1 -> 3, then clear with a sample present.
      drive(1'b1, 1'b1, codes[5]);
      feed(6); feed(7); feed(0); feed(1); feed(3);
      drive(1'b1, 1'b1, codes[4]);
      // Hold handling.
      feed(0); feed(1); feed(2); feed(2); feed(2); feed(3);
      // en=0 holds state and drops pulses.
      drive(1'b0, 1'b0, 4'b0101);
      drive(1'b0, 1'b0, codes[7]);
      // Three revolutions, then async reset, then a too-short relock attempt.
      drive(1'b1, 1'b1, codes[0]);
      for (int p = 0; p < 27; p++) feed(p);
      async_reset();
      feed(0); feed(1);

      // Randomized walk around the code ring.
      cur = 1;
      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(99));
         k = int'($urandom_range(99));
         e = (r >= 8);
         c = (r >= 98);
         if (k < 75) cur = (cur + 1) % 8;
         else if (k < 83) cur = cur;
         else if (k < 92) cur = int'($urandom_range(7));
         code = codes[cur];
         if (k >= 92) begin
            code = 4'($urandom_range(15));
            while (lookup(code) >= 0) code = 4'($urandom_range(15));
         end
         drive(e, c, code);
         if (i % 500 == 499) async_reset();
      end

      @(posedge clk);
      #2;
      n_tests++;
      if (q_h.size() != 0 || q_s.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d/%0d responses outstanding, expected 0/0", q_h.size(), q_s.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
